ex_stage_buffer: RTL

Parametrised elastic pipeline-stage buffer that replaces the fixed single-register stage boundaries (ID/EX, EX/MEM) with a valid/ready handshake and DEPTH entries of storage. It absorbs multi-cycle EX back-pressure (e.g. ALU stall) without a global pipeline freeze. It supports the CP0 flush and the hazard-unit stall. Stage payloads (control bits, RegDstOut, ALUResult, ReadData2, ...) travel packed into one DATA_W vector.

---
 rtl/ex_stage_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/ex_stage_buffer.sv
// rtl/ex_stage_buffer.sv - elastic pipeline-stage buffer with valid/ready handshake, stall and flush
module ex_stage_buffer #(
    parameter int  DATA_W = 72,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              push;
    logic              pop;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready is built from registered occupancy only, so out_ready never reaches it.
    assign in_ready  = !stall && (count_q < CNT_W'(DEPTH));
    assign out_valid = !stall && (count_q != '0);
    assign out_data  = mem_q[head_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = in_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
